// File: rtl/br_updater.sv
// Branch resolution updater: turns resolved AGEX branch outcomes into the
// packed BHR/PHT/BTB update bus for the gshare/BTB predictor, raises the
// registered mispredict redirect to FE and keeps branch statistics.
module br_updater #(
  parameter int DBITS        = 32,
  parameter int BHR_BITS     = 8,
  parameter int BTB_IDX_BITS = 4,
  parameter int STAT_BITS    = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             res_valid,
  input  logic [DBITS-1:0]                 res_pc,
  input  logic                             res_taken,
  input  logic [DBITS-1:0]                 res_target,
  input  logic                             pred_taken,
  input  logic                             pred_btb_hit,
  input  logic [DBITS-1:0]                 pred_target,
  input  logic [BHR_BITS-1:0]              pred_pht_index,
  input  logic [1:0]                       pred_pht_ctr,
  output logic [2*BHR_BITS+2*DBITS+1:0]    from_updater_to_predictor,
  output logic                             mispredict,
  output logic [DBITS-1:0]                 redirect_pc,
  output logic [STAT_BITS-1:0]             stat_branches,
  output logic [STAT_BITS-1:0]             stat_mispredicts
);

  localparam int TAG_BITS   = DBITS - BTB_IDX_BITS - 2;
  localparam int ENTRY_BITS = TAG_BITS + 1 + DBITS;

  // Registered update-bus fields. The BHR field is the architectural history
  // itself, and the last PHT write (index/counter) doubles as the forwarding
  // entry: both are updated on every accepted branch and cleared on reset.
  logic                    is_branch;
  logic [BHR_BITS-1:0]     arch_bhr;
  logic [BHR_BITS-1:0]     pht_idx;
  logic [1:0]              pht_ctr;
  logic                    fwd_valid;
  logic [BTB_IDX_BITS-1:0] btb_idx;
  logic [ENTRY_BITS-1:0]   btb_entry;

  logic [1:0]              base_ctr;
  logic [1:0]              next_ctr;
  logic [BHR_BITS-1:0]     next_bhr;
  logic                    eff_taken;
  logic                    misp;
  logic [DBITS-1:0]        next_redirect;

  // Word-aligned PCs: the low two bits never reach the BTB.
  logic unused_pc_bits;
  assign unused_pc_bits = ^res_pc[1:0];

  // Resolution datapath: forwarded counter, saturating update, history shift,
  // mispredict detection and the correct fetch PC.
  always_comb begin
    base_ctr      = (fwd_valid && pht_idx == pred_pht_index) ? pht_ctr : pred_pht_ctr;
    next_ctr      = base_ctr;
    if (res_taken) begin
      if (base_ctr != 2'd3) next_ctr = base_ctr + 2'd1;
    end else begin
      if (base_ctr != 2'd0) next_ctr = base_ctr - 2'd1;
    end
    next_bhr      = {arch_bhr[BHR_BITS-2:0], res_taken};
    eff_taken     = pred_taken & pred_btb_hit;
    misp          = (eff_taken != res_taken) ||
                    (res_taken && eff_taken && (pred_target != res_target));
    next_redirect = res_taken ? res_target : res_pc + DBITS'(4);
  end

  // Output and state registers: pulses for one cycle per branch, data fields
  // hold across idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_branch        <= 1'b0;
      arch_bhr         <= '0;
      pht_idx          <= '0;
      pht_ctr          <= '0;
      fwd_valid        <= 1'b0;
      btb_idx          <= '0;
      btb_entry        <= '0;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      is_branch  <= res_valid;
      mispredict <= res_valid & misp;
      if (res_valid) begin
        arch_bhr      <= next_bhr;
        pht_idx       <= pred_pht_index;
        pht_ctr       <= next_ctr;
        fwd_valid     <= 1'b1;
        btb_idx       <= res_pc[BTB_IDX_BITS+1:2];
        btb_entry     <= {res_pc[DBITS-1:BTB_IDX_BITS+2], 1'b1, res_target};
        redirect_pc   <= next_redirect;
        stat_branches <= stat_branches + STAT_BITS'(1);
        if (misp) stat_mispredicts <= stat_mispredicts + STAT_BITS'(1);
      end
    end
  end

  assign from_updater_to_predictor = {is_branch, arch_bhr, pht_idx, pht_ctr, btb_idx, btb_entry};

endmodule

// File: tb/tb_br_updater.sv
// Scoreboard bench for br_updater: stimulus pushes model predictions tagged
// with the cycle they are due; a negedge monitor pops and compares.
module tb_br_updater;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        pred_taken;
  logic        pred_btb_hit;
  logic [31:0] pred_target;
  logic [7:0]  pred_pht_index;
  logic [1:0]  pred_pht_ctr;
  logic [81:0] bus;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  br_updater dut (
    .clk(clk), .reset(reset), .res_valid(res_valid), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target), .pred_taken(pred_taken),
    .pred_btb_hit(pred_btb_hit), .pred_target(pred_target),
    .pred_pht_index(pred_pht_index), .pred_pht_ctr(pred_pht_ctr),
    .from_updater_to_predictor(bus), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [81:0] bus;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  // Reference model state: architectural history, last PHT write, counts.
  logic [7:0]  m_bhr;
  bit          m_fv;
  logic [7:0]  m_fi;
  int          m_fc;
  logic [31:0] m_sb, m_sm;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_bhr = 8'h00; m_fv = 0; m_fi = 8'h00; m_fc = 0; m_sb = 0; m_sm = 0;
  endtask

  task automatic idle();
    res_valid = 1'b0;
    step();
  endtask

  task automatic branch(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                        input bit pt, input bit hit, input logic [31:0] ptgt,
                        input logic [7:0] idx, input logic [1:0] ctr);
    exp_t e;
    int base, nc;
    bit eff, mp;
    res_valid = 1'b1; res_pc = pc; res_taken = t; res_target = tgt;
    pred_taken = pt; pred_btb_hit = hit; pred_target = ptgt;
    pred_pht_index = idx; pred_pht_ctr = ctr;
    base = (m_fv && m_fi == idx) ? m_fc : int'(ctr);
    nc   = t ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
    m_fv = 1; m_fi = idx; m_fc = nc;
    m_bhr = {m_bhr[6:0], t};
    eff = pt & hit;
    mp  = (eff != t) || (t && eff && ptgt != tgt);
    m_sb = m_sb + 1;
    if (mp) m_sm = m_sm + 1;
    e.due = cyc + 1;
    e.bus = {1'b1, m_bhr, idx, 2'(nc), pc[5:2], pc[31:6], 1'b1, tgt};
    e.mp  = mp;
    e.rpc = t ? tgt : pc + 32'd4;
    e.sb  = m_sb;
    e.sm  = m_sm;
    q.push_back(e);
    step();
  endtask

  // Reset for one cycle (optionally offering a branch that must be dropped),
  // then check the cleared state.
  task automatic rst(input bit with_branch);
    reset = 1'b1;
    res_valid = with_branch;
    res_pc = $urandom; res_taken = 1'b1; res_target = $urandom;
    pred_taken = 1'b0; pred_btb_hit = 1'b0; pred_pht_index = 8'h00; pred_pht_ctr = 2'd1;
    model_reset();
    step();
    reset = 1'b0;
    res_valid = 1'b0;
    @(negedge clk);
    chk("reset_bus", 128'(bus), 128'(0));
    chk("reset_mispredict", 128'(mispredict), 128'(0));
    chk("reset_redirect", 128'(redirect_pc), 128'(0));
    chk("reset_stats", {64'd0, stat_branches, stat_mispredicts}, 128'(0));
    step();
  endtask

  // Monitor: the entry due this cycle must be presented now; otherwise the
  // strobes must be low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("missed_update", 128'(q[0].due), 128'(cyc));
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("update_bus", 128'(bus), 128'(e.bus));
        chk("mispredict", 128'(mispredict), 128'(e.mp));
        if (e.mp) chk("redirect_pc", 128'(redirect_pc), 128'(e.rpc));
        chk("stat_branches", 128'(stat_branches), 128'(e.sb));
        chk("stat_mispredicts", 128'(stat_mispredicts), 128'(e.sm));
      end else begin
        chk("idle_strobes", 128'({bus[81], mispredict}), 128'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seq [9];
    reset = 1'b1; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    pred_taken = 1'b0; pred_btb_hit = 1'b0; pred_target = '0;
    pred_pht_index = '0; pred_pht_ctr = '0;
    model_reset();
    step();
    mon_en = 1;
    rst(0);

    // First branch after reset: BHR 0x01, counter 2->3, tag 0x41, index 0.
    branch(32'h0000_1040, 1, 32'h0000_2000, 1, 0, 32'h0, 8'h12, 2'd2);
    idle();

    // Same index back-to-back with a stale zero counter: 1,2,3 then saturate.
    repeat (4) branch(32'h0000_0200, 1, 32'h0000_0280, 1, 1, 32'h0000_0280, 8'h05, 2'd0);
    idle();

    // Not-taken at 0, with and without predicted-taken.
    branch(32'h0000_0100, 0, 32'h0000_0180, 0, 0, 32'h0, 8'h20, 2'd0);
    branch(32'h0000_0100, 0, 32'h0000_0180, 1, 1, 32'h0000_0180, 8'h21, 2'd0);

    // Taken with correct direction: wrong target, then right target.
    branch(32'h0000_0500, 1, 32'h0000_0400, 1, 1, 32'h0000_0300, 8'h30, 2'd1);
    branch(32'h0000_0500, 1, 32'h0000_0400, 1, 1, 32'h0000_0400, 8'h31, 2'd1);
    idle();

    // History sequence T,N,T,T,N,N,T,N,T from reset; last eight outcomes
    // N,T,T,N,N,T,N,T give 0110_0101.
    rst(0);
    seq = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      branch(32'h0000_0800 + 32'(i * 4), seq[i], 32'h0000_0900, seq[i], 1,
             32'h0000_0900, 8'(8'h40 + i), 2'd1);
      if (i % 3 == 2) idle();
    end
    idle();
    chk("bhr_after_seq", 128'(bus[80:73]), 128'(8'h65));
    chk("branches_after_seq", 128'(stat_branches), 128'(9));

    // Randomized traffic; narrow index range to exercise forwarding.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle();
      else begin
        logic [31:0] pc, tgt, ptgt;
        pc   = $urandom;
        tgt  = $urandom;
        ptgt = $urandom_range(1) ? tgt : $urandom;
        branch(pc, 1'($urandom), tgt, 1'($urandom), 1'($urandom), ptgt,
               8'($urandom_range(3)), 2'($urandom));
      end
    end

    // Reset the cycle after a branch, with another branch offered during reset.
    branch(32'h0000_0a00, 1, 32'h0000_0b00, 0, 0, 32'h0, 8'h07, 2'd3);
    rst(1);
    idle();
    idle();

    repeat (3) idle();
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
